// File: rtl/fcs32_check.sv
// Streaming Ethernet FCS-32 checker with hold-back of the trailing four bytes.
// Optional good/bad frame statistics counters: define FCS32_CHECK_STATS_EN.
module fcs32_check #(
  parameter int DW_BYTES = 4,
  parameter int MW       = (DW_BYTES > 1) ? $clog2(DW_BYTES) : 1
) (
  input  logic                  pclk_i,
  input  logic                  rstn_i,
  input  logic [8*DW_BYTES-1:0] data_i,
  input  logic                  val_i,
  input  logic                  sof_i,
  input  logic                  eof_i,
  input  logic [MW-1:0]         mod_i,
  output logic                  done_o,
  output logic                  ok_o,
  output logic                  runt_o,
  output logic                  abort_o,
  output logic [31:0]           fcs_o,
  output logic [31:0]           rcv_o,
  output logic [15:0]           len_o,
  output logic [15:0]           good_o,
  output logic [15:0]           bad_o
);

  localparam int DW   = 8 * DW_BYTES;
  localparam int CW   = DW + 32;
  localparam int HOLD = 4;

  typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

  // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first on the wire.
  function automatic logic [31:0] fcs32_8(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ({1'b0, c[31:1]} ^ 32'hEDB8_8320) : {1'b0, c[31:1]};
    end
    return c;
  endfunction

  // Final complement, byte-ordered as the FCS appears on the wire.
  function automatic logic [31:0] fcs32_brev(input logic [31:0] crc);
    logic [31:0] x;
    x = ~crc;
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  state_t          state_q, state_d;
  logic            in_val_q, in_sof_q, in_eof_q;
  logic [DW-1:0]   in_data_q;
  logic [MW-1:0]   in_mod_q;
  logic [31:0]     crc_q, crc_d, win_q, win_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [15:0]     len_q, len_d;
  logic            fin_q, fin_d, runt_q, runt_d, abort_d;

  logic            accept_s;
  logic [4:0]      nb_s;
  logic [5:0]      tot_s;
  logic [16:0]     len_sum_s;
  logic [CW-1:0]   comb_s;
  logic [31:0]     crc_v, win_v;
  logic [2:0]      cnt_v;
  logic [15:0]     len_v;

  always_ff @(posedge pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      in_val_q  <= 1'b0;
      in_sof_q  <= 1'b0;
      in_eof_q  <= 1'b0;
      in_data_q <= {DW{1'b0}};
      in_mod_q  <= {MW{1'b0}};
    end else begin
      in_val_q <= val_i;
      if (val_i) begin
        in_sof_q  <= sof_i;
        in_eof_q  <= eof_i;
        in_data_q <= data_i;
        in_mod_q  <= mod_i;
      end
    end
  end

  // The window is prepended to the new bytes; everything older than the
  // newest four bytes goes through the CRC, the newest four stay held back.
  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    fin_d    = 1'b0;
    runt_d   = 1'b0;
    abort_d  = 1'b0;
    accept_s = in_val_q && (in_sof_q || (state_q == FRAME));
    nb_s     = (in_eof_q && (in_mod_q != {MW{1'b0}})) ? 5'(in_mod_q) : 5'(DW_BYTES);
    crc_v    = in_sof_q ? 32'hFFFF_FFFF : crc_q;
    win_v    = in_sof_q ? 32'h0000_0000 : win_q;
    cnt_v    = in_sof_q ? 3'd0 : cnt_q;
    len_v    = in_sof_q ? 16'h0000 : len_q;
    comb_s   = {win_v, in_data_q};
    for (int i = 0; i < DW_BYTES; i++) begin
      crc_v = ((i + int'(cnt_v) >= HOLD) && (i < int'(nb_s)))
              ? fcs32_8(crc_v, comb_s[CW-1-8*i -: 8]) : crc_v;
    end
    tot_s     = 6'(cnt_v) + 6'(nb_s);
    len_sum_s = 17'(len_v) + 17'(nb_s);
    if (accept_s) begin
      abort_d = in_sof_q && (state_q == FRAME);
      crc_d   = crc_v;
      win_d   = 32'(comb_s >> (8 * (DW_BYTES - int'(nb_s))));
      cnt_d   = (tot_s >= 6'd4) ? 3'd4 : tot_s[2:0];
      len_d   = len_sum_s[16] ? 16'hFFFF : len_sum_s[15:0];
      if (in_eof_q) begin
        state_d = IDLE;
        fin_d   = 1'b1;
        runt_d  = (tot_s < 6'd4);
      end else begin
        state_d = FRAME;
      end
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      crc_q   <= 32'hFFFF_FFFF;
      win_q   <= 32'h0000_0000;
      cnt_q   <= 3'd0;
      len_q   <= 16'h0000;
      fin_q   <= 1'b0;
      runt_q  <= 1'b0;
      abort_o <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      fin_q   <= fin_d;
      runt_q  <= runt_d;
      abort_o <= abort_d;
    end
  end

  // crc_q/win_q still hold the finished frame here even if a new sof was
  // processed on this same edge, so back-to-back frames are not lost.
  always_ff @(posedge pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      done_o <= 1'b0;
      ok_o   <= 1'b0;
      runt_o <= 1'b0;
      fcs_o  <= 32'h0000_0000;
      rcv_o  <= 32'h0000_0000;
      len_o  <= 16'h0000;
    end else begin
      done_o <= fin_q;
      if (fin_q) begin
        fcs_o  <= fcs32_brev(crc_q);
        rcv_o  <= runt_q ? 32'h0000_0000 : win_q;
        ok_o   <= ~runt_q & (fcs32_brev(crc_q) == win_q);
        runt_o <= runt_q;
        len_o  <= len_q;
      end
    end
  end

`ifdef FCS32_CHECK_STATS_EN
  logic [15:0] good_q, bad_q;
  logic [16:0] good_sum_s, bad_sum_s;

  assign good_sum_s = {1'b0, good_q} + {16'h0000, done_o & ok_o};
  assign bad_sum_s  = {1'b0, bad_q} + {16'h0000, done_o & ~ok_o} + {16'h0000, abort_o};

  // Saturating statistics, one cycle behind the result/abort pulses.
  always_ff @(posedge pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      good_q <= 16'h0000;
      bad_q  <= 16'h0000;
    end else begin
      good_q <= good_sum_s[16] ? 16'hFFFF : good_sum_s[15:0];
      bad_q  <= bad_sum_s[16] ? 16'hFFFF : bad_sum_s[15:0];
    end
  end

  assign good_o = good_q;
  assign bad_o  = bad_q;
`else
  assign good_o = 16'h0000;
  assign bad_o  = 16'h0000;
`endif

endmodule

// File: tb/tb_fcs32_check.sv
// Self-checking bench for fcs32_check: directed vectors on 4-byte and 1-byte
// datapaths plus random frames checked against a whole-frame CRC-32 model.
module tb_fcs32_check;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic        ok;
    logic        runt;
    logic [31:0] fcs;
    logic [31:0] rcv;
    logic [15:0] len;
    int          cyc;
  } res_t;
  typedef struct {
    string        name;
    int           n;
    logic [127:0] b;
    bit           gaps;
    bit           fcs_chk;
    logic [31:0]  fcs;
    logic [31:0]  rcv;
    logic         ok;
    logic         runt;
    logic [15:0]  len;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] d4_data;
  logic        d4_val, d4_sof, d4_eof;
  logic [1:0]  d4_mod;
  logic        d4_done, d4_ok, d4_runt, d4_abort;
  logic [31:0] d4_fcs, d4_rcv;
  logic [15:0] d4_len, d4_good, d4_bad;

  logic [7:0]  d1_data;
  logic        d1_val, d1_sof, d1_eof;
  logic [0:0]  d1_mod;
  logic        d1_done, d1_ok, d1_runt, d1_abort;
  logic [31:0] d1_fcs, d1_rcv;
  logic [15:0] d1_len, d1_good, d1_bad;

  fcs32_check #(.DW_BYTES(4)) u_dut4 (
    .pclk_i(clk), .rstn_i(rstn), .data_i(d4_data), .val_i(d4_val), .sof_i(d4_sof),
    .eof_i(d4_eof), .mod_i(d4_mod), .done_o(d4_done), .ok_o(d4_ok), .runt_o(d4_runt),
    .abort_o(d4_abort), .fcs_o(d4_fcs), .rcv_o(d4_rcv), .len_o(d4_len),
    .good_o(d4_good), .bad_o(d4_bad)
  );

  fcs32_check #(.DW_BYTES(1)) u_dut1 (
    .pclk_i(clk), .rstn_i(rstn), .data_i(d1_data), .val_i(d1_val), .sof_i(d1_sof),
    .eof_i(d1_eof), .mod_i(d1_mod), .done_o(d1_done), .ok_o(d1_ok), .runt_o(d1_runt),
    .abort_o(d1_abort), .fcs_o(d1_fcs), .rcv_o(d1_rcv), .len_o(d1_len),
    .good_o(d1_good), .bad_o(d1_bad)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   abort4 = 0;
  int   exp_good [2];
  int   exp_bad [2];
  res_t r4_q[$];
  res_t r1_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (d4_done) r4_q.push_back('{d4_ok, d4_runt, d4_fcs, d4_rcv, d4_len, cyc});
    if (d1_done) r1_q.push_back('{d1_ok, d1_runt, d1_fcs, d1_rcv, d1_len, cyc});
    if (d4_abort) abort4++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: standard Ethernet CRC-32 over the payload, bit-serial.
  function automatic logic [31:0] crc32_ref(input bq_t q, input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ q[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  function automatic res_t model(input bq_t q);
    res_t        r;
    int          n;
    logic [31:0] c;
    n      = q.size();
    c      = crc32_ref(q, (n >= 4) ? n - 4 : 0);
    r.fcs  = {c[7:0], c[15:8], c[23:16], c[31:24]};
    r.runt = (n < 4);
    r.rcv  = r.runt ? 32'h0 : {q[n-4], q[n-3], q[n-2], q[n-1]};
    r.ok   = !r.runt && (r.fcs == r.rcv);
    r.len  = (n > 65535) ? 16'hFFFF : 16'(n);
    r.cyc  = 0;
    return r;
  endfunction

  function automatic bq_t mkrand(input int n, input bit good);
    bq_t         q;
    logic [31:0] c;
    if (good && n >= 4) begin
      for (int i = 0; i < n - 4; i++) q.push_back(8'($urandom));
      c = crc32_ref(q, n - 4);
      q.push_back(c[7:0]);
      q.push_back(c[15:8]);
      q.push_back(c[23:16]);
      q.push_back(c[31:24]);
    end else begin
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    end
    return q;
  endfunction

  function automatic bq_t vec2q(input vec_t v);
    bq_t q;
    for (int i = 0; i < v.n; i++) q.push_back(v.b[127-8*i -: 8]);
    return q;
  endfunction

  function automatic vec_t mk(input string nm, input int n, input logic [127:0] b, input bit gaps,
                              input bit fc, input logic [31:0] fcs, input logic [31:0] rcv,
                              input logic ok, input logic runt, input logic [15:0] len);
    vec_t v;
    v.name = nm; v.n = n; v.b = b; v.gaps = gaps; v.fcs_chk = fc;
    v.fcs = fcs; v.rcv = rcv; v.ok = ok; v.runt = runt; v.len = len;
    return v;
  endfunction

  task automatic drv4(input logic v, input logic s, input logic e, input logic [31:0] d, input logic [1:0] m);
    @(negedge clk);
    d4_val = v; d4_sof = s; d4_eof = e; d4_data = d; d4_mod = m;
  endtask

  task automatic idle4();
    drv4(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)));
  endtask

  task automatic drv1(input logic v, input logic s, input logic e, input logic [7:0] d, input logic m);
    @(negedge clk);
    d1_val = v; d1_sof = s; d1_eof = e; d1_data = d; d1_mod = m;
  endtask

  task automatic idle1();
    drv1(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic send4(input bq_t q, input bit gaps);
    int          n;
    int          nw;
    logic [31:0] w;
    n  = q.size();
    nw = (n + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) idle4();
      for (int b = 0; b < 4; b++) w[31-8*b -: 8] = (4 * i + b < n) ? q[4*i+b] : 8'($urandom);
      drv4(1'b1, i == 0, i == nw - 1, w, (i == nw - 1) ? 2'(n % 4) : 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic send1(input bq_t q, input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      if (gaps && i > 0 && $urandom_range(0, 2) == 0) idle1();
      drv1(1'b1, i == 0, i == q.size() - 1, q[i], 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic expect_res(input bit sel1, input string nm, input res_t e, input bit fcs_chk, output res_t got);
    int t;
    t   = 0;
    got = '{default: 0};
    while (((sel1 ? r1_q.size() : r4_q.size()) == 0) && t < 40) begin
      if (sel1) idle1(); else idle4();
      t++;
    end
    if ((sel1 ? r1_q.size() : r4_q.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done_o, expected one", nm);
      return;
    end
    got = sel1 ? r1_q.pop_front() : r4_q.pop_front();
    chk({nm, " ok"}, 32'(got.ok), 32'(e.ok));
    chk({nm, " runt"}, 32'(got.runt), 32'(e.runt));
    chk({nm, " rcv"}, got.rcv, e.rcv);
    chk({nm, " len"}, 32'(got.len), 32'(e.len));
    if (fcs_chk) chk({nm, " fcs"}, got.fcs, e.fcs);
    else chk({nm, " fcs!=rcv"}, 32'(got.fcs != got.rcv), 32'h1);
    if (e.ok) exp_good[sel1]++;
    else exp_bad[sel1]++;
  endtask

  task automatic chk_stats(input string nm);
`ifdef FCS32_CHECK_STATS_EN
    chk({nm, " good4"}, 32'(d4_good), 32'(exp_good[0]));
    chk({nm, " bad4"}, 32'(d4_bad), 32'(exp_bad[0]));
    chk({nm, " good1"}, 32'(d1_good), 32'(exp_good[1]));
    chk({nm, " bad1"}, 32'(d1_bad), 32'(exp_bad[1]));
`else
    chk({nm, " good4"}, 32'(d4_good), 32'h0);
    chk({nm, " bad4"}, 32'(d4_bad), 32'h0);
`endif
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " done"}, 32'(d4_done), 32'h0);
    chk({nm, " ok"}, 32'(d4_ok), 32'h0);
    chk({nm, " runt"}, 32'(d4_runt), 32'h0);
    chk({nm, " abort"}, 32'(d4_abort), 32'h0);
    chk({nm, " fcs"}, d4_fcs, 32'h0);
    chk({nm, " rcv"}, d4_rcv, 32'h0);
    chk({nm, " len"}, 32'(d4_len), 32'h0);
    chk({nm, " good"}, 32'(d4_good), 32'h0);
    chk({nm, " bad"}, 32'(d4_bad), 32'h0);
    chk({nm, " len1"}, 32'(d1_len), 32'h0);
  endtask

  initial begin
    vec_t         vecs [7];
    logic [127:0] good_b;
    logic [127:0] bad_b;
    bq_t          q;
    res_t         e;
    res_t         got;
    res_t         got2;
    logic         dn [1:4];
    int           a0;

    good_b = 128'h3132_3334_3536_3738_3926_39F4_CB00_0000;
    bad_b  = 128'h3132_3334_3436_3738_3926_39F4_CB00_0000;
    vecs[0] = mk("good",      13, good_b, 1'b0, 1'b1, 32'h2639F4CB, 32'h2639F4CB, 1'b1, 1'b0, 16'd13);
    vecs[1] = mk("good_gaps", 13, good_b, 1'b1, 1'b1, 32'h2639F4CB, 32'h2639F4CB, 1'b1, 1'b0, 16'd13);
    vecs[2] = mk("corrupt",   13, bad_b,  1'b0, 1'b0, 32'h0,        32'h2639F4CB, 1'b0, 1'b0, 16'd13);
    vecs[3] = mk("runt3",     3,  128'h616263 << 104, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 16'd3);
    vecs[4] = mk("four_zero", 4,  128'h0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 16'd4);
    vecs[5] = mk("four_beef", 4,  128'hDEADBEEF << 96, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 16'd4);
    vecs[6] = mk("one_byte",  1,  128'hA5 << 120, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 16'd1);

    d4_val = 1'b0; d4_sof = 1'b0; d4_eof = 1'b0; d4_data = 32'h0; d4_mod = 2'd0;
    d1_val = 1'b0; d1_sof = 1'b0; d1_eof = 1'b0; d1_data = 8'h0; d1_mod = 1'b0;
    exp_good = '{0, 0};
    exp_bad  = '{0, 0};

    #2;
    chk_zero("reset");
    chk("reset done1", 32'(d1_done), 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) idle4();

    for (int i = 0; i < 7; i++) begin
      q = vec2q(vecs[i]);
      send4(q, vecs[i].gaps);
      e = '{vecs[i].ok, vecs[i].runt, vecs[i].fcs, vecs[i].rcv, vecs[i].len, 0};
      expect_res(1'b0, vecs[i].name, e, vecs[i].fcs_chk, got);
    end
    repeat (2) idle4();
    chk_stats("table");

    q = vec2q(vecs[0]);
    send1(q, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      idle1();
      dn[c] = d1_done;
    end
    chk("dw1 done c2", 32'(dn[2]), 32'h0);
    chk("dw1 done c3", 32'(dn[3]), 32'h1);
    chk("dw1 done c4", 32'(dn[4]), 32'h0);
    e = '{1'b1, 1'b0, 32'h2639F4CB, 32'h2639F4CB, 16'd13, 0};
    expect_res(1'b1, "dw1_good", e, 1'b1, got);

    for (int f = 0; f < 24; f++) begin
      q = mkrand($urandom_range(1, 30), 1'($urandom_range(0, 1)));
      send4(q, 1'($urandom_range(0, 1)));
      expect_res(1'b0, $sformatf("rnd4_%0d", f), model(q), 1'b1, got);
    end
    for (int f = 0; f < 10; f++) begin
      q = mkrand($urandom_range(1, 12), 1'($urandom_range(0, 1)));
      send1(q, 1'b1);
      expect_res(1'b1, $sformatf("rnd1_%0d", f), model(q), 1'b1, got);
    end
    repeat (2) idle1();
    chk_stats("random");

    a0 = abort4;
    drv4(1'b1, 1'b1, 1'b0, $urandom, 2'd0);
    drv4(1'b1, 1'b0, 1'b0, $urandom, 2'd0);
    drv4(1'b1, 1'b0, 1'b0, $urandom, 2'd0);
    q = vec2q(vecs[0]);
    send4(q, 1'b0);
    expect_res(1'b0, "abort_good", model(q), 1'b1, got);
    exp_bad[0]++;
    repeat (4) idle4();
    chk("abort pulses", 32'(abort4 - a0), 32'h1);
    chk("abort extra done", 32'(r4_q.size()), 32'h0);
    chk_stats("abort");

    drv4(1'b1, 1'b1, 1'b0, $urandom, 2'd0);
    drv4(1'b1, 1'b0, 1'b0, $urandom, 2'd0);
    @(negedge clk);
    rstn = 1'b0;
    d4_val = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rstn = 1'b1;
    exp_good = '{0, 0};
    exp_bad  = '{0, 0};
    repeat (6) idle4();
    chk("no done after reset", 32'(r4_q.size()), 32'h0);

    send4(q, 1'b0);
    send4(q, 1'b0);
    expect_res(1'b0, "b2b_1", model(q), 1'b1, got);
    expect_res(1'b0, "b2b_2", model(q), 1'b1, got2);
    chk("b2b spacing", 32'(got2.cyc - got.cyc), 32'd4);
    repeat (2) idle4();
    chk_stats("b2b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
